// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Two-requester write-port arbiter for a register file. Requesters A and B
//   present {Valid, Reg, Data}. Ready is granted combinationally in the same
//   cycle. When both requesters are valid, the grant alternates round-robin.
//   An accepted request becomes a registered register-file write one cycle
//   later.
//   Writes that target DISCARD_REG are accepted but never written. Each one
//   increments a saturating drop counter instead.
//
// Ports:
//   Clock            - clock, all state updates on the rising edge
//   Resetn           - synchronous active-low reset
//   Stall            - when 1, neither requester is accepted
//   AValid/AReg/AData, AReady - requester A request and same-cycle accept
//   BValid/BReg/BData, BReady - requester B request and same-cycle accept
//   RegWrite         - register-file write enable (registered)
//   WriteReg         - register-file write address (held while RegWrite=0)
//   WriteData        - register-file write data    (held while RegWrite=0)
//   LastGrant        - most recently accepted requester (0=A, 1=B)
//   DropCount        - saturating count of writes dropped to DISCARD_REG
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 5,
   parameter int DISCARD_REG = 31
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Stall,
   input  logic              AValid,
   input  logic [ADDR_W-1:0] AReg,
   input  logic [DATA_W-1:0] AData,
   output logic              AReady,
   input  logic              BValid,
   input  logic [ADDR_W-1:0] BReg,
   input  logic [DATA_W-1:0] BData,
   output logic              BReady,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              LastGrant,
   output logic [7:0]        DropCount
);

   localparam logic [ADDR_W-1:0] DISCARD_ADDR = ADDR_W'(DISCARD_REG);
   localparam logic [7:0]        DROP_MAX     = 8'hFF;

   logic              run;
   logic              accept;
   logic              pick_b;
   logic              discard;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;

   // Grant logic. Ready is gated by Resetn even though the reset is
   // synchronous, so nothing is accepted in a cycle that is being reset.
   // On conflict the winner is the requester that did not win last time.
   always_comb begin
      // NOTE: every signal of a combinational block is assigned on every
      // path. A path that leaves one unassigned infers a latch.
      run      = Resetn & ~Stall;
      AReady   = run & AValid & (~BValid | LastGrant);
      BReady   = run & BValid & (~AValid | ~LastGrant);
      accept   = AReady | BReady;
      pick_b   = BReady;
      sel_reg  = pick_b ? BReg  : AReg;
      sel_data = pick_b ? BData : AData;
      discard  = (sel_reg == DISCARD_ADDR);
   end

   // Registered write port and arbitration history.
   always_ff @(posedge Clock) begin
      // NOTE: state uses non-blocking assignments. All registers then update
      // together from the values they held before the edge.
      if (!Resetn) begin
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
         LastGrant <= 1'b1;   // A wins the first conflict after reset
         DropCount <= '0;
      end else begin
         RegWrite <= accept & ~discard;
         if (accept) begin
            LastGrant <= pick_b;
            if (discard) begin
               if (DropCount != DROP_MAX) begin
                  DropCount <= DropCount + 8'd1;
               end
            end else begin
               // Address/data load only on a real write. They hold otherwise.
               WriteReg  <= sel_reg;
               WriteData <= sel_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter with default parameters
// (DATA_W=64, ADDR_W=5, DISCARD_REG=31). It has three parts:
//   1. A directed vector table with hand-derived expected values.
//   2. Hand-written multi-cycle sequences: write during stall and drop-count
//      saturation.
//   3. Randomized traffic checked against a behavioural reference model.
// Inputs change 1 time unit after the rising edge. Ready is sampled
// mid-cycle. Registered outputs are sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        Stall;
   logic        AValid;
   logic [4:0]  AReg;
   logic [63:0] AData;
   logic        AReady;
   logic        BValid;
   logic [4:0]  BReg;
   logic [63:0] BData;
   logic        BReady;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [63:0] WriteData;
   logic        LastGrant;
   logic [7:0]  DropCount;

   int errors = 0;
   int checks = 0;

   always #5 Clock = ~Clock;

   regfile_write_arbiter dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .Stall     (Stall),
      .AValid    (AValid),
      .AReg      (AReg),
      .AData     (AData),
      .AReady    (AReady),
      .BValid    (BValid),
      .BReg      (BReg),
      .BData     (BData),
      .BReady    (BReady),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .LastGrant (LastGrant),
      .DropCount (DropCount)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic rstn, input logic stall,
                        input logic av, input logic [4:0] ar, input logic [63:0] ad,
                        input logic bv, input logic [4:0] br, input logic [63:0] bd);
      Resetn = rstn; Stall = stall;
      AValid = av; AReg = ar; AData = ad;
      BValid = bv; BReg = br; BData = bd;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rstn, stall;
      logic        av; logic [4:0] ar; logic [63:0] ad;
      logic        bv; logic [4:0] br; logic [63:0] bd;
      logic        e_ar, e_br;                        // Ready during the cycle
      logic        e_rw; logic [4:0] e_wr; logic [63:0] e_wd;
      logic        e_last; logic [7:0] e_drop;        // outputs after the edge
   } vec_t;

   vec_t vecs[18];

   // ---------------- reference model ----------------
   // State that the specification says is visible after each clock edge.
   logic        m_rw;
   logic [4:0]  m_wr;
   logic [63:0] m_wd;
   int          m_last;
   int          m_drop;

   // Returns the requester accepted this cycle: -1 for none, 0 for A, 1 for B.
   function automatic int winner(input logic rstn, input logic stall,
                                 input logic av, input logic bv);
      if (!rstn || stall)  return -1;
      if (av && bv)        return (m_last == 1) ? 0 : 1;
      if (av)              return 0;
      if (bv)              return 1;
      return -1;
   endfunction

   task automatic model_step(input logic rstn, input int g,
                             input logic [4:0] ar, input logic [63:0] ad,
                             input logic [4:0] br, input logic [63:0] bd);
      logic [4:0]  r;
      logic [63:0] d;
      if (!rstn) begin
         m_rw = 0; m_wr = 0; m_wd = 0; m_last = 1; m_drop = 0;
      end else if (g < 0) begin
         m_rw = 0;
      end else begin
         r = (g == 1) ? br : ar;
         d = (g == 1) ? bd : ad;
         m_last = g;
         if (r == 5'd31) begin
            m_rw = 0;
            if (m_drop < 255) m_drop++;
         end else begin
            m_rw = 1; m_wr = r; m_wd = d;
         end
      end
   endtask

   // Runs one randomized cycle and checks every output against the model.
   task automatic rnd_step(input logic rstn, input logic stall,
                           input logic av, input logic [4:0] ar, input logic [63:0] ad,
                           input logic bv, input logic [4:0] br, input logic [63:0] bd,
                           output int g);
      drive(rstn, stall, av, ar, ad, bv, br, bd);
      g = winner(rstn, stall, av, bv);
      #1;
      check("rnd_aready", AReady, (g == 0) ? 64'd1 : 64'd0);
      check("rnd_bready", BReady, (g == 1) ? 64'd1 : 64'd0);
      tick();
      model_step(rstn, g, ar, ad, br, bd);
      check("rnd_regwrite", RegWrite, m_rw);
      check("rnd_writereg", WriteReg, m_wr);
      check("rnd_writedata", WriteData, m_wd);
      check("rnd_lastgrant", LastGrant, m_last);
      check("rnd_dropcount", DropCount, m_drop);
   endtask

   initial begin
      int nready;
      int g;
      logic        av, bv, rstn, stall;
      logic [4:0]  ar, br;
      logic [63:0] ad, bd;
      logic        a_pend, b_pend;

      //           rstn stall av ar     ad        bv br     bd        eAR eBR eRW eWR    eWD       eLast eDrop
      vecs[0]  = '{L, L, H, 5'd1,  64'h11,   H, 5'd2,  64'h22,   L, L, L, 5'd0, 64'h0,    H, 8'd0};
      vecs[1]  = '{L, L, L, 5'd0,  64'h0,    L, 5'd0,  64'h0,    L, L, L, 5'd0, 64'h0,    H, 8'd0};
      vecs[2]  = '{H, L, H, 5'd5,  64'hDEAD, L, 5'd0,  64'h0,    H, L, H, 5'd5, 64'hDEAD, L, 8'd0};
      vecs[3]  = '{H, L, L, 5'd0,  64'h0,    L, 5'd0,  64'h0,    L, L, L, 5'd5, 64'hDEAD, L, 8'd0};
      vecs[4]  = '{L, L, L, 5'd0,  64'h0,    L, 5'd0,  64'h0,    L, L, L, 5'd0, 64'h0,    H, 8'd0};
      vecs[5]  = '{H, L, H, 5'd1,  64'hA1,   H, 5'd2,  64'hB1,   H, L, H, 5'd1, 64'hA1,   L, 8'd0};
      vecs[6]  = '{H, L, H, 5'd1,  64'hA2,   H, 5'd2,  64'hB1,   L, H, H, 5'd2, 64'hB1,   H, 8'd0};
      vecs[7]  = '{H, L, H, 5'd1,  64'hA2,   H, 5'd2,  64'hB2,   H, L, H, 5'd1, 64'hA2,   L, 8'd0};
      vecs[8]  = '{H, L, H, 5'd1,  64'hA3,   H, 5'd2,  64'hB2,   L, H, H, 5'd2, 64'hB2,   H, 8'd0};
      vecs[9]  = '{H, L, L, 5'd0,  64'h0,    H, 5'd31, 64'hF1,   L, H, L, 5'd2, 64'hB2,   H, 8'd1};
      vecs[10] = '{H, L, L, 5'd0,  64'h0,    H, 5'd31, 64'hF2,   L, H, L, 5'd2, 64'hB2,   H, 8'd2};
      vecs[11] = '{H, L, L, 5'd0,  64'h0,    H, 5'd31, 64'hF3,   L, H, L, 5'd2, 64'hB2,   H, 8'd3};
      vecs[12] = '{H, L, H, 5'd7,  64'h77,   L, 5'd0,  64'h0,    H, L, H, 5'd7, 64'h77,   L, 8'd3};
      vecs[13] = '{H, H, H, 5'd8,  64'h88,   H, 5'd9,  64'h99,   L, L, L, 5'd7, 64'h77,   L, 8'd3};
      vecs[14] = '{H, H, H, 5'd8,  64'h88,   H, 5'd9,  64'h99,   L, L, L, 5'd7, 64'h77,   L, 8'd3};
      vecs[15] = '{H, H, H, 5'd8,  64'h88,   H, 5'd9,  64'h99,   L, L, L, 5'd7, 64'h77,   L, 8'd3};
      vecs[16] = '{H, L, H, 5'd9,  64'h99,   L, 5'd0,  64'h0,    H, L, H, 5'd9, 64'h99,   L, 8'd3};
      vecs[17] = '{L, L, H, 5'd9,  64'h99,   L, 5'd0,  64'h0,    L, L, L, 5'd0, 64'h0,    H, 8'd0};

      drive(L, L, L, 5'd0, 64'h0, L, 5'd0, 64'h0);
      tick();

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].rstn, vecs[i].stall, vecs[i].av, vecs[i].ar, vecs[i].ad,
               vecs[i].bv, vecs[i].br, vecs[i].bd);
         #1;
         check($sformatf("v%0d_aready", i), AReady, vecs[i].e_ar);
         check($sformatf("v%0d_bready", i), BReady, vecs[i].e_br);
         tick();
         check($sformatf("v%0d_regwrite", i), RegWrite, vecs[i].e_rw);
         check($sformatf("v%0d_writereg", i), WriteReg, vecs[i].e_wr);
         check($sformatf("v%0d_writedata", i), WriteData, vecs[i].e_wd);
         check($sformatf("v%0d_lastgrant", i), LastGrant, vecs[i].e_last);
         check($sformatf("v%0d_dropcount", i), DropCount, vecs[i].e_drop);
      end

      // A write accepted just before a stall still pulses while Stall=1.
      drive(H, L, H, 5'd3, 64'h33, L, 5'd0, 64'h0);
      #1;
      check("stall_pre_aready", AReady, 1);
      tick();
      drive(H, H, H, 5'd4, 64'h44, H, 5'd6, 64'h66);
      #1;
      check("stall_pulse_regwrite", RegWrite, 1);
      check("stall_pulse_writereg", WriteReg, 5'd3);
      check("stall_pulse_writedata", WriteData, 64'h33);
      check("stall_aready", AReady, 0);
      check("stall_bready", BReady, 0);
      tick();
      check("stall_after_regwrite", RegWrite, 0);
      check("stall_lastgrant_held", LastGrant, 0);

      // Drop counter saturation: 260 discarded accepts from B.
      drive(L, L, L, 5'd0, 64'h0, L, 5'd0, 64'h0);
      tick();
      drive(H, L, L, 5'd0, 64'h0, H, 5'd31, 64'hFFFF);
      nready = 0;
      for (int i = 0; i < 260; i++) begin
         #1;
         if (BReady !== 1'b1) nready++;
         tick();
         if (i == 253) check("drop_at_254", DropCount, 8'd254);
         if (i == 254) check("drop_at_255", DropCount, 8'd255);
         if (RegWrite !== 1'b0) nready++;
      end
      check("discard_ready_no_write_misses", nready, 0);
      check("drop_saturated", DropCount, 8'd255);

      // Randomized traffic against the reference model. The first cycle is a
      // reset so that model and DUT start from the same state.
      a_pend = 0; b_pend = 0;
      av = 0; bv = 0; ar = 0; br = 0; ad = 0; bd = 0;
      rnd_step(L, L, L, 5'd0, 64'h0, L, 5'd0, 64'h0, g);
      for (int i = 0; i < 3000; i++) begin
         rstn  = ($urandom_range(0, 63) != 0);
         stall = ($urandom_range(0, 3) == 0);
         // A requester that was not accepted keeps its request stable.
         if (!a_pend) begin
            av = ($urandom_range(0, 1) == 1);
            ar = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            ad = {$urandom, $urandom};
         end
         if (!b_pend) begin
            bv = ($urandom_range(0, 1) == 1);
            br = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            bd = {$urandom, $urandom};
         end
         rnd_step(rstn, stall, av, ar, ad, bv, br, bd, g);
         a_pend = av && (g != 0);
         b_pend = bv && (g != 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 64, meaning the write-data width.
REQ-002 The block SHALL have the parameter ADDR_W, default 5, meaning the register-address width.
REQ-003 The block SHALL have the parameter DISCARD_REG, default 31, meaning the zero-register address; writes to it are accepted and dropped.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 The block SHALL have the port Clock, input, 1 bit: clock; all state updates on the posedge.
REQ-006 The block SHALL have the port Resetn, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have the port Stall, input, 1 bit: when 1, no request is accepted.
REQ-008 The block SHALL have the port AValid, input, 1 bit: requester A write request.
REQ-009 The block SHALL have the port AReg, input, ADDR_W bits: requester A destination register.
REQ-010 The block SHALL have the port AData, input, DATA_W bits: requester A write data.
REQ-011 The block SHALL have the port AReady, output, 1 bit: requester A accepted this cycle.
REQ-012 The block SHALL have the ports BValid, BReg, BData and BReady, identical in direction and width to the A ports, for requester B.
REQ-013 The block SHALL have the port RegWrite, output, 1 bit: register-file write enable.
REQ-014 The block SHALL have the port WriteReg, output, ADDR_W bits: register-file write address.
REQ-015 The block SHALL have the port WriteData, output, DATA_W bits: register-file write data.
REQ-016 The block SHALL have the port LastGrant, output, 1 bit: the most recent accepted requester (0=A, 1=B).
REQ-017 The block SHALL have the port DropCount, output, 8 bits: saturating count of writes dropped because they targeted DISCARD_REG.

Function
REQ-018 An accept SHALL occur when Valid and Ready are both 1 at a Clock posedge, and at most one accept SHALL occur per cycle.
REQ-019 AReady and BReady SHALL be combinational, both 0 when Resetn=0 or Stall=1, and at most one SHALL be 1 in any cycle.
REQ-020 With exactly one Valid=1 and no stall, that requester's Ready SHALL be 1 in the same cycle.
REQ-021 With both Valid=1 and no stall, the grant SHALL go to the requester not equal to LastGrant (round-robin).
REQ-022 LastGrant SHALL update to the accepted requester on every accept and SHALL hold when no accept occurs, including during stall.
REQ-023 A requester SHALL hold Reg and Data stable while Valid=1 and Ready=0; the block SHALL NOT check this.
REQ-024 An accept with Reg != DISCARD_REG SHALL produce RegWrite=1 in the next cycle, with WriteReg/WriteData equal to the accepted Reg/Data (1-cycle latency, registered outputs).
REQ-025 An accept with Reg == DISCARD_REG SHALL produce RegWrite=0 in the next cycle and SHALL increment DropCount, saturating at 255.
REQ-026 In any cycle without an accept, RegWrite SHALL be 0 in the next cycle.
REQ-027 WriteReg and WriteData SHALL hold their last values whenever RegWrite=0.
REQ-028 Back-to-back accepts to the same register SHALL each produce a separate write, in accept order, with no merging.
REQ-029 When not stalled, a continuously valid requester SHALL be accepted within 2 cycles.
REQ-030 Stall SHALL NOT cancel a write already accepted in the previous cycle; that RegWrite pulse SHALL still occur.

Reset
REQ-031 When Resetn=0 at a posedge, the block SHALL set RegWrite=0, WriteReg=0, WriteData=0, LastGrant=1 and DropCount=0.
REQ-032 With LastGrant=1 after reset, requester A SHALL win the first conflict.
REQ-033 A write accepted in the cycle before reset SHALL be lost, with RegWrite=0 after reset.
REQ-034 AReady and BReady SHALL be 0 throughout reset.

Verification
REQ-035 Scenario (reset): hold Resetn=0 for 2 cycles, then release -> all outputs 0, LastGrant=1, and both Ready outputs 0 during reset.
REQ-036 Scenario (single requester): AValid=1, AReg=5, AData=0xDEAD, alone -> AReady=1 that cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0xDEAD.
REQ-037 Scenario (contention): both Valid held for 4 cycles with distinct data, starting from reset -> grant order A, B, A, B, with 4 consecutive RegWrite pulses carrying the matching data.
REQ-038 Scenario (discard): BReg=31 accepted 3 times -> BReady=1 each time, no RegWrite pulse, DropCount=3; after 260 such accepts, DropCount=255.
REQ-039 Scenario (stall): both Valid with Stall=1 for 3 cycles -> Ready outputs 0 and LastGrant unchanged; a write accepted in the cycle before the stall still pulses RegWrite.
REQ-040 Scenario (mid-operation reset): accept A, assert Resetn=0 in the next cycle -> RegWrite=0 and WriteReg=0 after that edge.
